grid_display_driver: RTL
========================

// Module: grid_display_driver
// PURPOSE
//  Scans the 64-bit Game-of-Life grid onto an external 8x8 LED matrix. The matrix is
//  driven through two daisy-chained 8-bit serial-in/parallel-out shift registers.
//  Sits downstream of the generation register and consumes its 64-bit grid output.
//  Snapshots one grid per frame, so a mid-scan evolution never tears the display.
//  Emits frame_done; the top level can use it to pace generations.
// PARAMETERS
//  CLK_DIV  2  clk cycles per sclk half-period (>=1)
// PORTS
//  clk         in   1   system clock, all state on rising edge
//  reset       in   1   asynchronous, active-high; clears all state and outputs
//  grid_in     in   64  cell state; cell(row r, col c) = grid_in[8*r+c]
//  enable      in   1   1 = scan frames continuously; 0 = stop after the current frame
//  sdata       out  1   serial data to shift-register chain
//  sclk        out  1   shift clock; the external chain samples sdata on its rising edge
//  latch       out  1   storage-register clock; high for CLK_DIV cycles per row
//  frame_done  out  1   1-cycle pulse after row 7 latch completes
//  row_idx     out  3   row currently being shifted or latched
// BEHAVIOUR
//  - Reset values: sdata=0, sclk=0, latch=0, frame_done=0, row_idx=0.
//  - On reset: state=IDLE; the frame snapshot register and shift register are cleared.
//  - Asserting reset mid-operation forces all outputs to their reset values immediately, without waiting for a clock edge.
//  - FSM states: IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH.
//  - IDLE: outputs at their reset values. When enable=1, go to LOAD on the next edge.
//  - LOAD (1 cycle):
//      - if row_idx==0, snapshot grid_in into the frame register;
//      - load shreg[15:0] = {frame[8*row+7 : 8*row], ~(8'b1 << row)};
//      - the low byte is the row select, one-hot active-low;
//      - bit_cnt=0; next state SHIFT_LO.
//  - SHIFT_LO (CLK_DIV cycles): sclk=0, sdata=shreg[15].
//  - SHIFT_HI (CLK_DIV cycles): sclk=1, sdata held.
//      - On exit: shreg <<= 1 and bit_cnt++.
//      - If this was bit 15, go to LATCH; otherwise go to SHIFT_LO.
//  - Shift order per row: col7..col0, then row-select bits 7..0 (MSB first, 16 bits).
//  - LATCH (CLK_DIV cycles): latch=1, sclk=0, sdata=0. On exit:
//      - row_idx<7: row_idx++ and go to LOAD;
//      - row_idx==7: row_idx=0, frame_done=1 for the next cycle,
//        then go to LOAD if enable=1, else IDLE.
//  - Timing: row = 1 + 33*CLK_DIV cycles; frame = 8*(1 + 33*CLK_DIV).
//    With CLK_DIV=2: 67 cycles per row, 536 per frame.
//  - enable is sampled only in IDLE and at the end of row 7.
//    A deassert mid-frame always completes the frame and pulses frame_done.
//  - grid_in changes during a frame are ignored until the next row-0 LOAD.
//  - Divider counter width is $clog2(CLK_DIV+1); it reloads on every state entry.
//  - row_idx wraps 7 -> 0 only via the LATCH exit; there is no other wrap path.
//  - sclk and latch are never high in the same cycle.
// STRUCTURE
//  display_pkg:
//    - GRID_W=8, ROW_W=3, ROW_BITS=16;
//    - typedef enum logic [2:0] disp_state_t {IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH}.
//  Sub-module row_shifter:
//    - 16-bit parallel-load, left-shift register;
//    - ports clk, reset, load, shift, din[15:0], msb.
//  The FSM, divider, row counter and frame register stay in grid_display_driver.
// TESTING
//  1 Reset: assert reset during SHIFT_HI of row 2 -> sclk/sdata/latch/frame_done=0 and
//    row_idx=0 before the next clk edge. Release with enable=1 -> LOAD on row 0.
//  2 Row decode: CLK_DIV=2, grid_in=64'h81, enable=1.
//    -> sdata at the 16 sclk rises = 1000_0001_1111_1110.
//    -> latch high exactly cycles 65-66 after LOAD.
//  3 Frame timing: grid_in=all ones.
//    -> row-select bytes FE,FD,FB,F7,EF,DF,BF,7F with column byte FF each;
//    -> frame_done pulses once, 536 cycles after the first LOAD.
//  4 Snapshot: change grid_in 64'h0 -> all ones during row 3.
//    -> rows 3-7 still shift 8'h00 columns;
//    -> next frame shows FF.
//  5 Enable drop: deassert enable in row 3.
//    -> rows 4-7 still shift, frame_done pulses, state IDLE;
//    -> sclk stays 0 for 1000 cycles.
//  6 Walking one: each grid_in = 1<<(8r+c) for all 64 positions.
//    -> only row r column byte has bit c set; scoreboard compares all 64.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types and constants for the 8x8 LED grid scan driver.
// Contents:
//   GRID_W / ROW_W / ROW_BITS / CELLS / BIT_W  geometry and counter widths
//   disp_state_t                               scan FSM state encoding
//   row_word()                                 16-bit word shifted out for one row
package display_pkg;

    localparam int unsigned GRID_W   = 8;
    localparam int unsigned ROW_W    = 3;
    localparam int unsigned ROW_BITS = 16;
    localparam int unsigned CELLS    = GRID_W * GRID_W;
    localparam int unsigned BIT_W    = $clog2(ROW_BITS);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } disp_state_t;

    // Column byte (col7 in the MSB, shifted first) followed by the active-low row select.
    function automatic logic [ROW_BITS-1:0] row_word(input logic [CELLS-1:0] frame,
                                                     input logic [ROW_W-1:0]  row);
        logic [GRID_W-1:0] sel;
        sel = ~(GRID_W'(1) << row);
        return {frame[GRID_W*row +: GRID_W], sel};
    endfunction

endpackage

// File: rtl/row_shifter.sv
// 16-bit parallel-load, left-shift register feeding the serial data pin.
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   load        capture din (has priority over shift)
//   shift       shift left by one, zero filled
//   din         parallel load value
//   msb         current bit 15
module row_shifter
    import display_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic                shift,
    input  logic [ROW_BITS-1:0] din,
    output logic                msb
);

    logic [ROW_BITS-1:0] shreg;

    // Shift register storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= din;
        end else if (shift) begin
            shreg <= {shreg[ROW_BITS-2:0], 1'b0};
        end
    end

    assign msb = shreg[ROW_BITS-1];

endmodule

// File: rtl/grid_display_driver.sv
// Scans a 64-cell Game-of-Life grid onto an 8x8 LED matrix through two
// daisy-chained 8-bit SIPO shift registers. One grid snapshot per frame.
// Ports:
//   clk         system clock
//   reset       asynchronous active-high reset
//   grid_in     cell(r,c) = grid_in[8*r+c]
//   enable      scan continuously while high; a frame in progress always completes
//   sdata       serial data to the shift-register chain
//   sclk        shift clock (chain samples sdata on its rising edge)
//   latch       storage-register clock, high CLK_DIV cycles per row
//   frame_done  one-cycle pulse after the row 7 latch
//   row_idx     row being shifted or latched
module grid_display_driver
    import display_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CELLS-1:0]    grid_in,
    input  logic                enable,
    output logic                sdata,
    output logic                sclk,
    output logic                latch,
    output logic                frame_done,
    output logic [ROW_W-1:0]    row_idx
);

    localparam int unsigned     DIV_W    = $clog2(CLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

    disp_state_t         state, state_next;
    logic [DIV_W-1:0]    div_cnt, div_next;
    logic [BIT_W-1:0]    bit_cnt, bit_next;
    logic [ROW_W-1:0]    row_next;
    logic [CELLS-1:0]    frame, frame_next;
    logic                sdata_next, sclk_next, latch_next, done_next;

    logic [CELLS-1:0]    row_src_c;
    logic [ROW_BITS-1:0] sh_din_c;
    logic                sh_load_c, sh_shift_c, div_last_c;
    logic                sh_msb;

    // Row 0 reads grid_in directly since the snapshot lands on the same edge.
    assign row_src_c  = (row_idx == '0) ? grid_in : frame;
    assign sh_din_c   = row_word(row_src_c, row_idx);
    assign div_last_c = (div_cnt == '0);

    row_shifter u_row_shifter (
        .clk   (clk),
        .reset (reset),
        .load  (sh_load_c),
        .shift (sh_shift_c),
        .din   (sh_din_c),
        .msb   (sh_msb)
    );

    // Next-state, counters and next output values.
    // The shifter advances as SHIFT_LO ends, so during SHIFT_HI its msb already
    // holds the following bit and sdata can be registered from it on SHIFT_HI exit.
    always_comb begin
        state_next = state;
        bit_next   = bit_cnt;
        row_next   = row_idx;
        frame_next = frame;
        sdata_next = 1'b0;
        done_next  = 1'b0;
        sh_load_c  = 1'b0;
        sh_shift_c = 1'b0;
        div_next   = div_cnt;

        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                if (row_idx == '0) begin
                    frame_next = grid_in;
                end
                sh_load_c  = 1'b1;
                bit_next   = '0;
                sdata_next = sh_din_c[ROW_BITS-1];
                state_next = SHIFT_LO;
            end
            SHIFT_LO: begin
                sdata_next = sdata;
                if (div_last_c) begin
                    sh_shift_c = 1'b1;
                    state_next = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                sdata_next = sdata;
                if (div_last_c) begin
                    bit_next = bit_cnt + BIT_W'(1);
                    if (bit_cnt == BIT_W'(ROW_BITS - 1)) begin
                        sdata_next = 1'b0;
                        state_next = LATCH;
                    end else begin
                        sdata_next = sh_msb;
                        state_next = SHIFT_LO;
                    end
                end
            end
            LATCH: begin
                if (div_last_c) begin
                    if (row_idx == ROW_W'(GRID_W - 1)) begin
                        row_next   = '0;
                        done_next  = 1'b1;
                        state_next = enable ? LOAD : IDLE;
                    end else begin
                        row_next   = row_idx + ROW_W'(1);
                        state_next = LOAD;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Divider reloads on every state entry.
        if (state_next != state) begin
            div_next = DIV_LOAD;
        end else if (!div_last_c) begin
            div_next = div_cnt - DIV_W'(1);
        end

        sclk_next  = (state_next == SHIFT_HI);
        latch_next = (state_next == LATCH);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            row_idx    <= '0;
            frame      <= '0;
            sdata      <= 1'b0;
            sclk       <= 1'b0;
            latch      <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_next;
            div_cnt    <= div_next;
            bit_cnt    <= bit_next;
            row_idx    <= row_next;
            frame      <= frame_next;
            sdata      <= sdata_next;
            sclk       <= sclk_next;
            latch      <= latch_next;
            frame_done <= done_next;
        end
    end

endmodule
